// File: rtl/mul_div_seq_nat_pkg.sv
// Shared types and constants for the iterative natural multiply-add / divide unit.
package mul_div_seq_nat_pkg;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Step counter must be able to hold 0..n.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/mul_div_seq_nat_mds_step.sv
// One radix-2 iteration: shift-right-add multiply or restoring divide, selected by op.
module mds_step
    import mul_div_seq_nat_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic         op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] q,
    input  logic [N-1:0] b,
    output logic [N-1:0] a_nxt,
    output logic [N-1:0] q_nxt
);

    logic [N:0]   sum;
    logic [N:0]   r_sh;
    logic [N+1:0] diff;
    logic         borrow;

    // Multiply: conditional add of the multiplicand, carry kept for the right shift.
    assign sum = {1'b0, a} + ((q[0]) ? {1'b0, b} : (N+1)'(0));

    // Divide: trial subtraction of the divisor from the left-shifted partial remainder.
    assign r_sh   = {a, q[N-1]};
    assign diff   = {1'b0, r_sh} - {2'b00, b};
    assign borrow = diff[N+1];

    always_comb begin
        a_nxt = a;
        q_nxt = q;
        if (op == OP_MUL) begin
            a_nxt = sum[N:1];
            q_nxt = {sum[0], q[N-1:1]};
        end else if (!borrow) begin
            a_nxt = diff[N-1:0];
            q_nxt = {q[N-2:0], 1'b1};
        end else begin
            a_nxt = r_sh[N-1:0];
            q_nxt = {q[N-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/mul_div_seq_nat.sv
// Iterative N-bit natural multiply-add (x*y+c) / divide ({c,x}/y) with valid-ready handshakes.
module mul_div_seq_nat
    import mul_div_seq_nat_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         op,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic [N-1:0] c,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] res_hi,
    output logic [N-1:0] res_lo,
    output logic         dz,
    output logic         ovf
);

    localparam int unsigned CW = cnt_width(N);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          op_q, op_d;
    logic [N-1:0]  acc_q, acc_d;
    logic [N-1:0]  qr_q, qr_d;
    logic [N-1:0]  b_q, b_d;
    logic [N-1:0]  res_hi_q, res_hi_d;
    logic [N-1:0]  res_lo_q, res_lo_d;
    logic          dz_q, dz_d;
    logic          ovf_q, ovf_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;

    logic [N-1:0]  acc_nxt;
    logic [N-1:0]  qr_nxt;

    mds_step #(.N(N)) u_step (
        .op    (op_q),
        .a     (acc_q),
        .q     (qr_q),
        .b     (b_q),
        .a_nxt (acc_nxt),
        .q_nxt (qr_nxt)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            op_q        <= OP_MUL;
            acc_q       <= '0;
            qr_q        <= '0;
            b_q         <= '0;
            res_hi_q    <= '0;
            res_lo_q    <= '0;
            dz_q        <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            acc_q       <= acc_d;
            qr_q        <= qr_d;
            b_q         <= b_d;
            res_hi_q    <= res_hi_d;
            res_lo_q    <= res_lo_d;
            dz_q        <= dz_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        acc_d    = acc_q;
        qr_d     = qr_q;
        b_d      = b_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        dz_d     = dz_q;
        ovf_d    = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    // Accumulator starts from c in both modes; b holds multiplicand or divisor.
                    op_d  = op;
                    cnt_d = '0;
                    dz_d  = 1'b0;
                    ovf_d = 1'b0;
                    acc_d = c;
                    qr_d  = (op == OP_MUL) ? y : x;
                    b_d   = (op == OP_MUL) ? x : y;
                    if (op == OP_DIV && y == '0) begin
                        state_d  = S_DONE;
                        dz_d     = 1'b1;
                        res_hi_d = '0;
                        res_lo_d = '0;
                    end else if (op == OP_DIV && c >= y) begin
                        state_d  = S_DONE;
                        ovf_d    = 1'b1;
                        res_hi_d = '0;
                        res_lo_d = '0;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                acc_d = acc_nxt;
                qr_d  = qr_nxt;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d  = S_DONE;
                    res_hi_d = acc_nxt;
                    res_lo_d = qr_nxt;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign res_hi    = res_hi_q;
    assign res_lo    = res_lo_q;
    assign dz        = dz_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_mul_div_seq_nat.sv
// Self-checking bench for mul_div_seq_nat (N=8) against an arithmetic reference model.
module tb_mul_div_seq_nat;

    localparam int unsigned N = 8;

    logic         clock;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic         op;
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic [N-1:0] c;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] res_hi;
    logic [N-1:0] res_lo;
    logic         dz;
    logic         ovf;

    int errors = 0;
    int checks = 0;

    mul_div_seq_nat #(.N(N)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .x         (x),
        .y         (y),
        .c         (c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res_hi    (res_hi),
        .res_lo    (res_lo),
        .dz        (dz),
        .ovf       (ovf)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    task automatic model(input logic op_i, input int unsigned xi, input int unsigned yi,
                         input int unsigned ci, output int unsigned hi, output int unsigned lo,
                         output logic edz, output logic eovf);
        int unsigned p;
        edz  = 1'b0;
        eovf = 1'b0;
        hi   = 0;
        lo   = 0;
        if (op_i == 1'b0) begin
            p  = xi * yi + ci;
            hi = p / (2 ** N);
            lo = p % (2 ** N);
        end else if (yi == 0) begin
            edz = 1'b1;
        end else if (ci >= yi) begin
            eovf = 1'b1;
        end else begin
            p  = ci * (2 ** N) + xi;
            lo = p / yi;
            hi = p % yi;
        end
    endtask

    // Issue one operation, hold the result for 'hold' cycles, then drain it.
    task automatic run_op(input string tag, input logic op_i, input int unsigned xi,
                          input int unsigned yi, input int unsigned ci, input int hold);
        int unsigned ehi, elo;
        logic        edz, eovf;
        int          lat, exp_lat;
        model(op_i, xi, yi, ci, ehi, elo, edz, eovf);
        // Edges after E0 until out_valid is observed: errors appear right after E0.
        exp_lat = (edz || eovf) ? 0 : N;

        @(negedge clock);
        in_valid = 1'b1;
        op = op_i;
        x  = N'(xi);
        y  = N'(yi);
        c  = N'(ci);
        check({tag, ":in_ready_idle"}, 32'(in_ready), 32'd1);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        x = N'($urandom);
        y = N'($urandom);
        c = N'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clock);
            #1;
            lat++;
        end
        check({tag, ":latency"}, 32'(lat), 32'(exp_lat));
        check({tag, ":res_hi"}, 32'(res_hi), ehi);
        check({tag, ":res_lo"}, 32'(res_lo), elo);
        check({tag, ":dz"}, 32'(dz), 32'(edz));
        check({tag, ":ovf"}, 32'(ovf), 32'(eovf));
        check({tag, ":in_ready_busy"}, 32'(in_ready), 32'd0);

        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            in_valid = 1'($urandom_range(0, 1));
            op = 1'($urandom_range(0, 1));
            x  = N'($urandom);
            y  = N'($urandom);
            c  = N'($urandom);
            @(posedge clock);
            #1;
            check({tag, ":hold"}, {12'd0, out_valid, in_ready, dz, ovf, res_hi, res_lo},
                  {12'd0, 1'b1, 1'b0, edz, eovf, 8'(ehi), 8'(elo)});
        end

        @(negedge clock);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        check({tag, ":drain"}, {30'd0, out_valid, in_ready}, {30'd0, 1'b0, 1'b1});
    endtask

    initial begin
        logic seen;
        logic rop;
        int unsigned rx, ry, rc;

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = 1'b0;
        x         = '0;
        y         = '0;
        c         = '0;
        repeat (2) @(posedge clock);
        #1;
        check("reset_state", {12'd0, in_ready, out_valid, dz, ovf, res_hi, res_lo},
              {12'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0});
        @(negedge clock);
        reset = 1'b0;

        run_op("mul_a", 1'b0, 200, 150, 55, 0);
        run_op("mul_max", 1'b0, 255, 255, 255, 0);
        run_op("mul_zero", 1'b0, 0, 0, 8'h5A, 0);
        run_op("div_a", 1'b1, 8'h34, 8'h56, 8'h12, 0);
        run_op("div_dz", 1'b1, 8'h77, 0, 8'h03, 1);
        run_op("div_ovf", 1'b1, 8'h20, 10, 10, 1);
        run_op("after_err", 1'b1, 8'hFF, 8'hFF, 8'hFE, 0);
        run_op("backpressure", 1'b0, 8'hAB, 8'hCD, 8'hEF, 5);
        run_op("div_bp", 1'b1, 8'h01, 8'h03, 8'h02, 5);

        for (int i = 0; i < 40; i++) begin
            rop = 1'($urandom_range(0, 1));
            rx  = $urandom_range(0, 255);
            ry  = $urandom_range(0, 255);
            rc  = $urandom_range(0, 255);
            if (rop && ry != 0 && $urandom_range(0, 3) != 0) rc = $urandom_range(0, ry - 1);
            run_op("rand", rop, rx, ry, rc, int'($urandom_range(0, 2)));
        end

        // Abort a multiply three cycles into its run.
        @(negedge clock);
        in_valid = 1'b1;
        op = 1'b0;
        x  = 8'd99;
        y  = 8'd77;
        c  = 8'd11;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        check("abort_state", {12'd0, in_ready, out_valid, dz, ovf, res_hi, res_lo},
              {12'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0});
        @(negedge clock);
        reset = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            @(posedge clock);
            #1;
            if (out_valid) seen = 1'b1;
        end
        check("abort_no_valid", 32'(seen), 32'd0);
        run_op("post_abort", 1'b0, 99, 77, 11, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
